// File: rtl/obstacle_scroller_pkg.sv
// Shared game package: game state encoding, obstacle height table and speed width.
package obstacle_scroller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int SPEED_W = 3;
    localparam int H_W     = 6;

    localparam logic [H_W-1:0] H_TYPE0 = 6'd15;
    localparam logic [H_W-1:0] H_TYPE1 = 6'd20;
    localparam logic [H_W-1:0] H_TYPE2 = 6'd30;
    localparam logic [H_W-1:0] H_TYPE3 = 6'd40;

    function automatic logic [H_W-1:0] height_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return H_TYPE0;
            2'd1:    return H_TYPE1;
            2'd2:    return H_TYPE2;
            default: return H_TYPE3;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_tick_gen.sv
// Movement tick generator: counts enabled RUN cycles and pulses tick once per TICK_MAX+1.
module obstacle_tick_gen #(
    parameter int TICK_MAX = 60000
) (
    input  logic clk,
    input  logic nRst,
    input  logic run,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (run && enable) begin
            if (cnt_q == CW'(TICK_MAX)) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/obstacle_scroller.sv
// Obstacle scroller: slots spawn at x=0 on ticks, advance by the current speed and retire
// past the screen edge; retirements raise the speed and request a redraw.
module obstacle_scroller
    import obstacle_scroller_pkg::*;
#(
    parameter int N_OBS     = 4,
    parameter int XW        = 9,
    parameter int SCREEN_W  = 320,
    parameter int TICK_MAX  = 60000,
    parameter int GAP_BASE  = 100,
    parameter int GAP_STEP  = 30,
    parameter int SPEED_MAX = 4,
    parameter int LEVEL_UP  = 8
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  state_t               state,
    input  logic                 enable,
    input  logic [1:0]           rng,
    input  logic [1:0]           type_in,
    input  logic                 draw_done,
    output logic [N_OBS*XW-1:0]  obs_x,
    output logic [N_OBS*6-1:0]   obs_h,
    output logic [N_OBS-1:0]     obs_active,
    output logic                 moved,
    output logic [SPEED_W-1:0]   speed,
    output logic [7:0]           passed
);

    localparam int GW = 16;

    logic                  tick;
    logic                  spawn;
    logic [N_OBS-1:0]      act_q, act_d;
    logic [N_OBS-1:0]      retire;
    logic [N_OBS-1:0]      free_sel;
    logic [N_OBS*XW-1:0]   x_q, x_d;
    logic [N_OBS*H_W-1:0]  h_q, h_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [GW-1:0]         gap_src;
    logic [SPEED_W-1:0]    speed_q, speed_d;
    logic [7:0]            passed_q, passed_d;
    logic [7:0]            lvl_q, lvl_d;
    logic                  moved_q, moved_d;

    obstacle_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick_gen (
        .clk    (clk),
        .nRst   (nRst),
        .run    (state == RUN),
        .enable (enable),
        .clear  (state == IDLE),
        .tick   (tick)
    );

    // Lowest-index slot free before this tick's retirements; a freed slot waits one tick.
    always_comb begin
        free_sel = '0;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            if (!act_q[i]) free_sel = N_OBS'(1) << i;
        end
    end

    assign spawn = tick && (gap_q == '0) && (|free_sel);

    for (genvar i = 0; i < N_OBS; i++) begin : g_slot
        logic [XW-1:0]  x_cur;
        logic [XW:0]    x_adv;
        logic           act_n;
        logic [XW-1:0]  x_n;
        logic [H_W-1:0] h_n;

        assign x_cur     = x_q[i*XW +: XW];
        assign x_adv     = {1'b0, x_cur} + (XW+1)'(speed_q);
        assign retire[i] = tick && act_q[i] && (x_adv >= (XW+1)'(SCREEN_W));

        always_comb begin
            act_n = act_q[i];
            x_n   = x_cur;
            h_n   = h_q[i*H_W +: H_W];
            if (state == IDLE) begin
                act_n = 1'b0;
                x_n   = '0;
                h_n   = '0;
            end else if (spawn && free_sel[i]) begin
                act_n = 1'b1;
                x_n   = '0;
                h_n   = height_of(type_in);
            end else if (retire[i]) begin
                act_n = 1'b0;
                x_n   = '0;
            end else if (tick && act_q[i]) begin
                x_n   = x_adv[XW-1:0];
            end
        end

        assign act_d[i]           = act_n;
        assign x_d[i*XW +: XW]    = x_n;
        assign h_d[i*H_W +: H_W]  = h_n;
    end

    // The spawn tick also consumes one step of the fresh gap, so spawns sit exactly gap pixels apart.
    assign gap_src = spawn ? (GW'(GAP_BASE) + GW'(rng) * GW'(GAP_STEP)) : gap_q;

    always_comb begin
        gap_d    = gap_q;
        passed_d = passed_q;
        lvl_d    = lvl_q;
        speed_d  = speed_q;
        if (state == IDLE) begin
            gap_d    = '0;
            passed_d = '0;
            lvl_d    = '0;
            speed_d  = SPEED_W'(1);
        end else if (tick) begin
            gap_d = (gap_src > GW'(speed_q)) ? gap_src - GW'(speed_q) : '0;
            for (int i = 0; i < N_OBS; i++) begin
                if (retire[i] && passed_d != 8'hFF) begin
                    passed_d = passed_d + 8'd1;
                    if (lvl_d == 8'(LEVEL_UP - 1)) begin
                        lvl_d = '0;
                        if (speed_d < SPEED_W'(SPEED_MAX)) speed_d = speed_d + 1'b1;
                    end else begin
                        lvl_d = lvl_d + 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        moved_d = moved_q;
        if (state == IDLE)                          moved_d = 1'b0;
        else if (act_d != act_q || x_d != x_q)      moved_d = 1'b1;
        else if (draw_done)                         moved_d = 1'b0;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            act_q    <= '0;
            x_q      <= '0;
            h_q      <= '0;
            gap_q    <= '0;
            speed_q  <= SPEED_W'(1);
            passed_q <= '0;
            lvl_q    <= '0;
            moved_q  <= 1'b0;
        end else begin
            act_q    <= act_d;
            x_q      <= x_d;
            h_q      <= h_d;
            gap_q    <= gap_d;
            speed_q  <= speed_d;
            passed_q <= passed_d;
            lvl_q    <= lvl_d;
            moved_q  <= moved_d;
        end
    end

    assign obs_x      = x_q;
    assign obs_h      = h_q;
    assign obs_active = act_q;
    assign moved      = moved_q;
    assign speed      = speed_q;
    assign passed     = passed_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller: directed scenarios plus randomized stimulus against a
// per-cycle behavioural model of the obstacle rules.
module tb_obstacle_scroller;
    import obstacle_scroller_pkg::*;

    localparam int N_OBS     = 2;
    localparam int XW        = 9;
    localparam int SCREEN_W  = 40;
    localparam int TICK_MAX  = 3;
    localparam int GAP_BASE  = 10;
    localparam int GAP_STEP  = 5;
    localparam int SPEED_MAX = 4;
    localparam int LEVEL_UP  = 2;
    localparam int VW        = N_OBS + N_OBS*XW + N_OBS*6 + 1 + 3 + 8;

    logic                clk = 1'b0;
    logic                nRst;
    state_t              st;
    logic                en, dd;
    logic [1:0]          rng_i, type_i;
    logic [N_OBS*XW-1:0] obs_x;
    logic [N_OBS*6-1:0]  obs_h;
    logic [N_OBS-1:0]    obs_active;
    logic                moved;
    logic [2:0]          speed;
    logic [7:0]          passed;
    logic [VW-1:0]       dut_vec;
    logic [VW-1:0]       saved;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    int m_cnt, m_gap, m_speed, m_passed;
    int m_x[N_OBS];
    int m_h[N_OBS];
    bit m_act[N_OBS];
    bit m_moved;
    int heights[4] = '{15, 20, 30, 40};

    obstacle_scroller #(
        .N_OBS(N_OBS), .XW(XW), .SCREEN_W(SCREEN_W), .TICK_MAX(TICK_MAX),
        .GAP_BASE(GAP_BASE), .GAP_STEP(GAP_STEP), .SPEED_MAX(SPEED_MAX), .LEVEL_UP(LEVEL_UP)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .state      (st),
        .enable     (en),
        .rng        (rng_i),
        .type_in    (type_i),
        .draw_done  (dd),
        .obs_x      (obs_x),
        .obs_h      (obs_h),
        .obs_active (obs_active),
        .moved      (moved),
        .speed      (speed),
        .passed     (passed)
    );

    always #5 clk = ~clk;

    assign dut_vec = {obs_active, obs_x, obs_h, moved, speed, passed};

    task automatic model_reset();
        m_cnt = 0; m_gap = 0; m_speed = 1; m_passed = 0; m_moved = 0;
        for (int i = 0; i < N_OBS; i++) begin
            m_x[i] = 0; m_h[i] = 0; m_act[i] = 0;
        end
    endtask

    // One clock of the game rules, using the inputs currently applied.
    task automatic model_step();
        bit tk, chg, do_spawn;
        int free, ret, np;
        tk = 0; chg = 0;
        if (st == IDLE) begin
            model_reset();
            return;
        end
        if (st == RUN && en) begin
            if (m_cnt == TICK_MAX) begin tk = 1; m_cnt = 0; end
            else m_cnt++;
        end
        if (tk) begin
            free = -1;
            for (int i = N_OBS - 1; i >= 0; i--) if (!m_act[i]) free = i;
            do_spawn = (m_gap == 0) && (free >= 0);
            ret = 0;
            for (int i = 0; i < N_OBS; i++) begin
                if (m_act[i]) begin
                    chg = 1;
                    if (m_x[i] + m_speed < SCREEN_W) m_x[i] += m_speed;
                    else begin m_act[i] = 0; m_x[i] = 0; ret++; end
                end
            end
            if (do_spawn) begin
                m_act[free] = 1; m_x[free] = 0; m_h[free] = heights[type_i]; chg = 1;
            end
            m_gap = (do_spawn ? GAP_BASE + int'(rng_i) * GAP_STEP : m_gap) - m_speed;
            if (m_gap < 0) m_gap = 0;
            np = m_passed + ret;
            if (np > 255) np = 255;
            m_speed += np / LEVEL_UP - m_passed / LEVEL_UP;
            if (m_speed > SPEED_MAX) m_speed = SPEED_MAX;
            m_passed = np;
        end
        if (chg) m_moved = 1;
        else if (dd) m_moved = 0;
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [N_OBS*XW-1:0] xv;
        logic [N_OBS*6-1:0]  hv;
        logic [N_OBS-1:0]    av;
        xv = '0; hv = '0; av = '0;
        for (int i = 0; i < N_OBS; i++) begin
            xv[i*XW +: XW] = XW'(m_x[i]);
            hv[i*6 +: 6]   = 6'(m_h[i]);
            av[i]          = m_act[i];
        end
        return {av, xv, hv, m_moved, 3'(m_speed), 8'(m_passed)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0; st = RUN; en = 1'b1; dd = 1'b0; rng_i = 2'd1; type_i = 2'd2;
        model_reset();
        #12;
        n_total++;
        if (dut_vec !== {2'b00, 18'd0, 12'd0, 1'b0, 3'd1, 8'd0})
            $display("FAIL reset_values got=%h exp=%h", dut_vec, {2'b00, 18'd0, 12'd0, 1'b0, 3'd1, 8'd0});
        else n_pass++;
        @(posedge clk); #1;
        nRst = 1'b1;
    endtask

    task automatic test_first_spawn();
        repeat (3) step();
        n_total++;
        if (obs_active !== 2'b00) $display("FAIL no_early_tick got=%b exp=00", obs_active);
        else n_pass++;
        step();
        n_total++;
        if ({obs_active, obs_x[8:0], obs_h[5:0], moved} !== {2'b01, 9'd0, 6'd30, 1'b1})
            $display("FAIL first_spawn got act=%b x0=%0d h0=%0d moved=%b exp act=01 x0=0 h0=30 moved=1",
                     obs_active, obs_x[8:0], obs_h[5:0], moved);
        else n_pass++;
    endtask

    task automatic test_second_spawn();
        dd = 1'b1;
        repeat (14 * 4) step();
        n_total++;
        if ({obs_active, obs_x[8:0]} !== {2'b01, 9'd14})
            $display("FAIL gap_wait got act=%b x0=%0d exp act=01 x0=14", obs_active, obs_x[8:0]);
        else n_pass++;
        type_i = 2'd1; rng_i = 2'd0;
        repeat (4) step();
        n_total++;
        if ({obs_active, obs_x, obs_h[11:6]} !== {2'b11, 9'd0, 9'd15, 6'd20})
            $display("FAIL second_spawn got act=%b x=%h h1=%0d exp act=11 x1=0 x0=15 h1=20",
                     obs_active, obs_x, obs_h[11:6]);
        else n_pass++;
        n_total++;
        if (dut_vec !== model_vec()) $display("FAIL second_spawn_model got=%h exp=%h", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_defer();
        dd = 1'b0;
        for (int t = 0; t < 24; t++) begin
            repeat (4) step();
            n_total++;
            if (dut_vec !== model_vec()) $display("FAIL defer_model t=%0d got=%h exp=%h", t, dut_vec, model_vec());
            else n_pass++;
        end
        n_total++;
        if ({obs_active, obs_x} !== {2'b11, 9'd24, 9'd39})
            $display("FAIL full_no_spawn got act=%b x=%h exp act=11 x1=24 x0=39", obs_active, obs_x);
        else n_pass++;
        rng_i = 2'd3;
        repeat (4) step();
        n_total++;
        if ({obs_active, obs_x, passed, speed} !== {2'b10, 9'd25, 9'd0, 8'd1, 3'd1})
            $display("FAIL retire_no_same_tick got act=%b x=%h passed=%0d speed=%0d exp act=10 x1=25 x0=0 passed=1 speed=1",
                     obs_active, obs_x, passed, speed);
        else n_pass++;
        repeat (4) step();
        n_total++;
        if ({obs_active, obs_x, obs_h[5:0]} !== {2'b11, 9'd26, 9'd0, 6'd20})
            $display("FAIL spawn_after_retire got act=%b x=%h h0=%0d exp act=11 x1=26 x0=0 h0=20",
                     obs_active, obs_x, obs_h[5:0]);
        else n_pass++;
    endtask

    task automatic test_level_up();
        repeat (13 * 4) step();
        n_total++;
        if ({obs_active, obs_x} !== {2'b11, 9'd39, 9'd13})
            $display("FAIL pre_level got act=%b x=%h exp act=11 x1=39 x0=13", obs_active, obs_x);
        else n_pass++;
        repeat (4) step();
        n_total++;
        if ({obs_active, obs_x, passed, speed} !== {2'b01, 9'd0, 9'd14, 8'd2, 3'd2})
            $display("FAIL level_up got act=%b x=%h passed=%0d speed=%0d exp act=01 x1=0 x0=14 passed=2 speed=2",
                     obs_active, obs_x, passed, speed);
        else n_pass++;
        repeat (4) step();
        n_total++;
        if (obs_x[8:0] !== 9'd16) $display("FAIL speed2_advance got x0=%0d exp 16", obs_x[8:0]);
        else n_pass++;
    endtask

    task automatic test_pause();
        repeat (2) step();
        en = 1'b0;
        saved = model_vec();
        repeat (20) step();
        n_total++;
        if (dut_vec !== saved) $display("FAIL pause_hold got=%h exp=%h", dut_vec, saved);
        else n_pass++;
        en = 1'b1;
        step();
        n_total++;
        if (obs_x[8:0] !== 9'd16) $display("FAIL pause_count_held got x0=%0d exp 16", obs_x[8:0]);
        else n_pass++;
        step();
        n_total++;
        if (obs_x[8:0] !== 9'd18) $display("FAIL pause_resume_tick got x0=%0d exp 18", obs_x[8:0]);
        else n_pass++;
    endtask

    task automatic test_freeze();
        st = OVER; dd = 1'b0;
        saved = model_vec();
        repeat (20) begin
            rng_i = 2'($urandom_range(0, 3)); type_i = 2'($urandom_range(0, 3));
            step();
        end
        n_total++;
        if (dut_vec !== saved) $display("FAIL over_freeze got=%h exp=%h", dut_vec, saved);
        else n_pass++;
        st = WIN; dd = 1'b1;
        step();
        n_total++;
        if (dut_vec !== {saved[VW-1:12], 1'b0, saved[10:0]})
            $display("FAIL win_freeze_draw_done got=%h exp=%h", dut_vec, {saved[VW-1:12], 1'b0, saved[10:0]});
        else n_pass++;
    endtask

    task automatic test_idle();
        st = IDLE; dd = 1'b0;
        step();
        n_total++;
        if (dut_vec !== {2'b00, 18'd0, 12'd0, 1'b0, 3'd1, 8'd0})
            $display("FAIL idle_clear got=%h exp=%h", dut_vec, {2'b00, 18'd0, 12'd0, 1'b0, 3'd1, 8'd0});
        else n_pass++;
        st = RUN; type_i = 2'd3;
        repeat (4) step();
        n_total++;
        if ({obs_active, obs_x, obs_h} !== {2'b01, 18'd0, 6'd0, 6'd40})
            $display("FAIL idle_to_run_spawn got act=%b x=%h h=%h exp act=01 x=0 h0=40 h1=0",
                     obs_active, obs_x, obs_h);
        else n_pass++;
    endtask

    task automatic test_draw_done();
        dd = 1'b1;
        repeat (3) step();
        n_total++;
        if (moved !== 1'b0) $display("FAIL draw_done_clear got=%b exp=0", moved);
        else n_pass++;
        step();
        n_total++;
        if (moved !== 1'b1) $display("FAIL set_wins_over_clear got=%b exp=1", moved);
        else n_pass++;
        step();
        n_total++;
        if (moved !== 1'b0) $display("FAIL draw_done_alone got=%b exp=0", moved);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 12000; c++) begin
            r = int'($urandom_range(0, 999));
            if (c < 2000) st = (r == 0) ? IDLE : (r < 10) ? OVER : (r < 20) ? WIN : RUN;
            else          st = RUN;
            en     = ($urandom_range(0, 9) != 0);
            dd     = ($urandom_range(0, 3) == 0);
            rng_i  = 2'($urandom_range(0, 3));
            type_i = 2'($urandom_range(0, 3));
            step();
            n_total++;
            if (dut_vec !== model_vec()) $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_vec, model_vec());
            else n_pass++;
        end
        n_total++;
        if (speed > 3'(SPEED_MAX)) $display("FAIL speed_cap got=%0d exp<=%0d", speed, SPEED_MAX);
        else n_pass++;
        if (m_passed == 255) begin
            n_total++;
            if (passed !== 8'd255) $display("FAIL passed_saturate got=%0d exp=255", passed);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        st = RUN; en = 1'b1; dd = 1'b0;
        for (int k = 0; k < 8 && m_cnt != TICK_MAX; k++) step();
        @(negedge clk);
        nRst = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (dut_vec !== {2'b00, 18'd0, 12'd0, 1'b0, 3'd1, 8'd0})
            $display("FAIL async_reset got=%h exp=%h", dut_vec, {2'b00, 18'd0, 12'd0, 1'b0, 3'd1, 8'd0});
        else n_pass++;
        @(posedge clk); #1;
        nRst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_total++;
            if (dut_vec !== model_vec()) $display("FAIL post_reset_model k=%0d got=%h exp=%h", k, dut_vec, model_vec());
            else n_pass++;
        end
        n_total++;
        if (obs_active !== 2'b01) $display("FAIL post_reset_first_tick got=%b exp=01", obs_active);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_second_spawn();
        test_defer();
        test_level_up();
        test_pause();
        test_freeze();
        test_idle();
        test_draw_done();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
